// File: rtl/axi_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_slave_pkg
// Shared definitions for the AXI4 burst slave memory: burst-type and response
// codes, the supported beat size, write/read FSM state encodings, and a helper
// that decides whether a burst is one this slave can actually service.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_slave_pkg;

   // AXI burst types
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Only full 32-bit beats are serviced
   localparam logic [2:0] SIZE_4B     = 3'b010;

   // Write FSM states
   localparam logic [1:0] W_IDLE      = 2'd0;
   localparam logic [1:0] W_DATA      = 2'd1;
   localparam logic [1:0] W_RESP      = 2'd2;

   // Read FSM states
   localparam logic [0:0] R_IDLE      = 1'b0;
   localparam logic [0:0] R_DATA      = 1'b1;

   // True when the burst is INCR with 4-byte beats; anything else is answered
   // with SLVERR and never touches the storage.
   function automatic logic burst_supported(input logic [1:0] burst,
                                            input logic [2:0] size);
      logic ok;
      case (burst)
         BURST_FIXED: ok = 1'b0;
         BURST_INCR:  ok = (size == SIZE_4B);
         BURST_WRAP:  ok = 1'b0;
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/axi_slave_regfile.sv
// -----------------------------------------------------------------------------
// axi_slave_regfile
// Word-addressed storage with one byte-lane-masked synchronous write port and
// one asynchronous read port. Contents are deliberately not reset so a bus
// reset never destroys memory. A read of the word being written in the same
// cycle returns the old contents; the write lands at the clock edge.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write word address
//   i_wdata  write data
//   i_wstrb  per-byte write enables
//   i_raddr  read word address
//   o_rdata  read data (combinational from the array)
// -----------------------------------------------------------------------------
module axi_slave_regfile
   import axi_slave_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
)(
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DATA_W/8-1:0]   i_wstrb,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_W-1:0]     o_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   // Byte-lane write into the addressed word
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_burst_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_burst_slave_mem
// AXI4 slave memory responder. Independent write and read paths, each with one
// outstanding burst. INCR bursts of 4-byte beats are serviced; addresses wrap
// modulo the memory depth. Other burst types/sizes complete every handshake
// with SLVERR and never modify memory (reads return zero data).
// Ports:
//   ACLK / ARESET          clock, asynchronous active-high reset
//   S_AXI_AW*              write address channel (AWREADY out)
//   S_AXI_W*               write data channel (WREADY out)
//   S_AXI_B*               write response channel (BREADY in)
//   S_AXI_AR*              read address channel (ARREADY out)
//   S_AXI_R*               read data channel (RREADY in)
// Only C_S_AXI_DATA_WIDTH = 32 is supported.
// -----------------------------------------------------------------------------
module axi_burst_slave_mem
   import axi_slave_pkg::*;
#(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8
)(
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic [2:0]                      S_AXI_AWSIZE,
   input  logic [1:0]                      S_AXI_AWBURST,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic [2:0]                      S_AXI_ARSIZE,
   input  logic [1:0]                      S_AXI_ARBURST,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RLAST,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int WA = C_S_AXI_ADDR_WIDTH - 2;

   // ---------------------------------------------------------------- write path
   logic [1:0]                  r_w_state;
   logic [1:0]                  w_w_state_nxt;
   logic                        r_awready;
   logic                        r_wready;
   logic                        r_bvalid;
   logic [C_S_AXI_ID_WIDTH-1:0] r_bid;
   logic [1:0]                  r_bresp;
   logic [WA-1:0]               r_waddr;
   logic [7:0]                  r_awlen;
   logic                        r_w_ok;
   logic [8:0]                  r_wbeats;     // beats accepted so far in this burst

   logic                        w_aw_hs;
   logic                        w_w_hs;
   logic                        w_b_hs;
   logic                        w_mem_we;
   logic [8:0]                  w_wbeats_total;
   logic                        w_w_bad;

   assign w_aw_hs = r_awready & S_AXI_AWVALID;
   assign w_w_hs  = r_wready  & S_AXI_WVALID;
   assign w_b_hs  = r_bvalid  & S_AXI_BREADY;

   // Beats past AWLEN+1 are still acknowledged but never reach memory
   assign w_mem_we = w_w_hs & r_w_ok & (r_wbeats <= {1'b0, r_awlen});

   assign w_wbeats_total = r_wbeats + 9'd1;
   assign w_w_bad        = (~r_w_ok) | (w_wbeats_total != ({1'b0, r_awlen} + 9'd1));

   // Write FSM next-state decode
   always_comb begin
      w_w_state_nxt = r_w_state;
      case (r_w_state)
         W_IDLE: begin
            if (w_aw_hs) w_w_state_nxt = W_DATA;
            else         w_w_state_nxt = W_IDLE;
         end
         W_DATA: begin
            if (w_w_hs && S_AXI_WLAST) w_w_state_nxt = W_RESP;
            else                       w_w_state_nxt = W_DATA;
         end
         W_RESP: begin
            if (w_b_hs) w_w_state_nxt = W_IDLE;
            else        w_w_state_nxt = W_RESP;
         end
         default: w_w_state_nxt = W_IDLE;
      endcase
   end

   // Write FSM state, registered handshake outputs and burst context.
   // Ready/valid flags are registered from the next state so they all sit at
   // 0 during reset and AWREADY rises on the first edge after release.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_w_state <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= RESP_OKAY;
         r_waddr   <= '0;
         r_awlen   <= 8'd0;
         r_w_ok    <= 1'b0;
         r_wbeats  <= 9'd0;
      end else begin
         r_w_state <= w_w_state_nxt;
         r_awready <= (w_w_state_nxt == W_IDLE);
         r_wready  <= (w_w_state_nxt == W_DATA);
         r_bvalid  <= (w_w_state_nxt == W_RESP);
         if (w_aw_hs) begin
            r_bid    <= S_AXI_AWID;
            r_waddr  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            r_awlen  <= S_AXI_AWLEN;
            r_w_ok   <= burst_supported(S_AXI_AWBURST, S_AXI_AWSIZE);
            r_wbeats <= 9'd0;
         end else if (w_w_hs) begin
            r_waddr <= r_waddr + WA'(1);
            // Saturate so a runaway burst can never alias back to a legal count
            if (r_wbeats != 9'h1FF) begin
               r_wbeats <= w_wbeats_total;
            end
            if (S_AXI_WLAST) begin
               r_bresp <= w_w_bad ? RESP_SLVERR : RESP_OKAY;
            end
         end
      end
   end

   // ----------------------------------------------------------------- read path
   logic [0:0]                  r_r_state;
   logic [0:0]                  w_r_state_nxt;
   logic                        r_arready;
   logic                        r_rvalid;
   logic                        r_rlast;
   logic [C_S_AXI_ID_WIDTH-1:0] r_rid;
   logic [1:0]                  r_rresp;
   logic [WA-1:0]               r_raddr;
   logic [7:0]                  r_arlen;
   logic [7:0]                  r_rbeat;

   logic                        w_ar_hs;
   logic                        w_r_hs;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_mem_rdata;

   assign w_ar_hs = r_arready & S_AXI_ARVALID;
   assign w_r_hs  = r_rvalid  & S_AXI_RREADY;

   // Read FSM next-state decode
   always_comb begin
      w_r_state_nxt = r_r_state;
      case (r_r_state)
         R_IDLE: begin
            if (w_ar_hs) w_r_state_nxt = R_DATA;
            else         w_r_state_nxt = R_IDLE;
         end
         R_DATA: begin
            if (w_r_hs && r_rlast) w_r_state_nxt = R_IDLE;
            else                   w_r_state_nxt = R_DATA;
         end
         default: w_r_state_nxt = R_IDLE;
      endcase
   end

   // Read FSM state, registered handshake outputs and burst context.
   // RLAST is precomputed so it is valid together with the beat it marks.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_r_state <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_rresp   <= RESP_OKAY;
         r_raddr   <= '0;
         r_arlen   <= 8'd0;
         r_rbeat   <= 8'd0;
      end else begin
         r_r_state <= w_r_state_nxt;
         r_arready <= (w_r_state_nxt == R_IDLE);
         r_rvalid  <= (w_r_state_nxt == R_DATA);
         if (w_ar_hs) begin
            r_rid   <= S_AXI_ARID;
            r_raddr <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
            r_arlen <= S_AXI_ARLEN;
            r_rbeat <= 8'd0;
            r_rlast <= (S_AXI_ARLEN == 8'd0);
            r_rresp <= burst_supported(S_AXI_ARBURST, S_AXI_ARSIZE) ? RESP_OKAY : RESP_SLVERR;
         end else if (w_r_hs) begin
            r_raddr <= r_raddr + WA'(1);
            r_rbeat <= r_rbeat + 8'd1;
            if (r_rlast) r_rlast <= 1'b0;
            else         r_rlast <= ((r_rbeat + 8'd1) == r_arlen);
         end
      end
   end

   // ------------------------------------------------------------------ storage
   axi_slave_regfile #(
      .ADDR_W (WA),
      .DATA_W (C_S_AXI_DATA_WIDTH)
   ) u_regfile (
      .i_clk   (ACLK),
      .i_we    (w_mem_we),
      .i_waddr (r_waddr),
      .i_wdata (S_AXI_WDATA),
      .i_wstrb (S_AXI_WSTRB),
      .i_raddr (r_raddr),
      .o_rdata (w_mem_rdata)
   );

   // Sub-word address bits carry no meaning for 4-byte beats
   logic w_unused;
   assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // ------------------------------------------------------------------ outputs
   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BID     = r_bid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RLAST   = r_rlast;
   assign S_AXI_RID     = r_rid;
   assign S_AXI_RRESP   = r_rresp;
   // Error bursts and idle cycles present zero data
   assign S_AXI_RDATA   = (r_rvalid && (r_rresp == RESP_OKAY)) ? w_mem_rdata
                                                               : {C_S_AXI_DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_slave_mem
// Directed bench for axi_burst_slave_mem. Stimulus tasks push expected B
// responses and R beats into queues; an independent monitor pops and compares
// on every B/R handshake and also checks that stalled R beats hold steady.
// -----------------------------------------------------------------------------
module tb_axi_burst_slave_mem;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        ARESET;
   logic [0:0]  S_AXI_AWID;
   logic [7:0]  S_AXI_AWADDR;
   logic [7:0]  S_AXI_AWLEN;
   logic [2:0]  S_AXI_AWSIZE;
   logic [1:0]  S_AXI_AWBURST;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WLAST;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [0:0]  S_AXI_BID;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [0:0]  S_AXI_ARID;
   logic [7:0]  S_AXI_ARADDR;
   logic [7:0]  S_AXI_ARLEN;
   logic [2:0]  S_AXI_ARSIZE;
   logic [1:0]  S_AXI_ARBURST;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [0:0]  S_AXI_RID;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RLAST;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;

   axi_burst_slave_mem #(
      .C_S_AXI_ID_WIDTH   (1),
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (8)
   ) dut (
      .ACLK          (clk),
      .ARESET        (ARESET),
      .S_AXI_AWID    (S_AXI_AWID),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWLEN   (S_AXI_AWLEN),
      .S_AXI_AWSIZE  (S_AXI_AWSIZE),
      .S_AXI_AWBURST (S_AXI_AWBURST),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WLAST   (S_AXI_WLAST),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BID     (S_AXI_BID),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARID    (S_AXI_ARID),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARLEN   (S_AXI_ARLEN),
      .S_AXI_ARSIZE  (S_AXI_ARSIZE),
      .S_AXI_ARBURST (S_AXI_ARBURST),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RID     (S_AXI_RID),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RLAST   (S_AXI_RLAST),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [0:0]  id;
      logic [1:0]  resp;
   } b_exp_t;

   typedef struct packed {
      logic [0:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   b_exp_t      bq[$];
   r_exp_t      rq[$];
   logic [31:0] wd [0:15];
   logic        stall_mode = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_r(input logic [0:0] id, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
      r_exp_t e;
      e.id = id; e.data = data; e.resp = resp; e.last = last;
      rq.push_back(e);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk(name, 64'(bq.size() + rq.size()), 64'd0);
   endtask

   task automatic write_burst(input string name, input logic [7:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                              input logic [3:0] strb, input logic [0:0] id, input logic [1:0] resp);
      b_exp_t e;
      int     n;
      e.id = id; e.resp = resp;
      bq.push_back(e);
      @(posedge clk); #1;
      S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
      S_AXI_AWBURST = burst; S_AXI_AWSIZE = size; S_AXI_AWVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 50);
      if (!S_AXI_AWREADY) chk("aw_timeout", 64'(S_AXI_AWREADY), 64'd1);
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         S_AXI_WDATA = wd[i]; S_AXI_WSTRB = strb;
         S_AXI_WLAST = (i == nbeats - 1); S_AXI_WVALID = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!S_AXI_WREADY && n < 50);
         if (!S_AXI_WREADY) chk("w_timeout", 64'(S_AXI_WREADY), 64'd1);
         @(posedge clk); #1;
      end
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      drain(name);
   endtask

   task automatic read_burst(input string name, input logic [7:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [0:0] id);
      int n;
      @(posedge clk); #1;
      S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
      S_AXI_ARBURST = burst; S_AXI_ARSIZE = size; S_AXI_ARVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_ARREADY && n < 50);
      if (!S_AXI_ARREADY) chk("ar_timeout", 64'(S_AXI_ARREADY), 64'd1);
      @(posedge clk); #1;
      S_AXI_ARVALID = 1'b0;
      // first beat must be presented in the cycle right after the handshake
      @(negedge clk);
      chk("r_latency", 64'(S_AXI_RVALID), 64'd1);
      drain(name);
   endtask

   // RREADY driver: held high, or toggling every cycle when stalling is wanted
   initial begin
      S_AXI_RREADY = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_mode) S_AXI_RREADY = ~S_AXI_RREADY;
         else            S_AXI_RREADY = 1'b1;
      end
   end

   // Monitor: compare every B/R handshake against the queues, and check that a
   // stalled R beat is unchanged one cycle later.
   initial begin
      logic        prev_stall;
      logic [35:0] prev_r;
      b_exp_t      be;
      r_exp_t      re;
      prev_stall = 1'b0;
      prev_r     = '0;
      forever begin
         @(negedge clk);
         if (ARESET) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("r_hold", 64'({S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST}),
                   64'({1'b1, prev_r}));
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
               if (bq.size() == 0) begin
                  chk("b_unexpected", 64'(bq.size()), 64'd1);
               end else begin
                  be = bq.pop_front();
                  chk("b_resp", 64'({S_AXI_BID, S_AXI_BRESP}), 64'(be));
               end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
               if (rq.size() == 0) begin
                  chk("r_unexpected", 64'(rq.size()), 64'd1);
               end else begin
                  re = rq.pop_front();
                  chk("r_beat", 64'({S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST}), 64'(re));
               end
            end
            prev_stall = S_AXI_RVALID && !S_AXI_RREADY;
            prev_r     = {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      ARESET = 1'b1;
      S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
      S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b1;
      S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
      S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0;

      // ---- reset state
      repeat (3) @(negedge clk);
      chk("rst_ready_valid", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST}), 64'd0);
      chk("rst_fields", 64'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID, S_AXI_RDATA}), 64'd0);
      ARESET = 1'b0;
      #1;
      chk("awready_before_edge", 64'(S_AXI_AWREADY), 64'd0);
      @(negedge clk);
      chk("ready_after_release", 64'({S_AXI_AWREADY, S_AXI_ARREADY}), 64'b11);

      // ---- INCR len 3 write and readback
      wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
      write_burst("wr_incr4", 8'h10, 8'd3, 2'b01, 3'b010, 4, 4'hF, 1'b1, 2'b00);
      exp_r(1'b1, 32'hA0, 2'b00, 1'b0); exp_r(1'b1, 32'hA1, 2'b00, 1'b0);
      exp_r(1'b1, 32'hA2, 2'b00, 1'b0); exp_r(1'b1, 32'hA3, 2'b00, 1'b1);
      read_burst("rd_incr4", 8'h10, 8'd3, 2'b01, 3'b010, 1'b1);

      // ---- byte-lane strobe
      wd[0] = 32'hFFFF_FFFF;
      write_burst("wr_full", 8'h20, 8'd0, 2'b01, 3'b010, 1, 4'hF, 1'b0, 2'b00);
      wd[0] = 32'h0000_1200;
      write_burst("wr_lane1", 8'h20, 8'd0, 2'b01, 3'b010, 1, 4'h2, 1'b0, 2'b00);
      exp_r(1'b0, 32'hFFFF_12FF, 2'b00, 1'b1);
      read_burst("rd_strobe", 8'h20, 8'd0, 2'b01, 3'b010, 1'b0);

      // ---- address wrap at top of memory
      wd[0] = 32'h11; wd[1] = 32'h22;
      write_burst("wr_wrap_addr", 8'hFC, 8'd1, 2'b01, 3'b010, 2, 4'hF, 1'b1, 2'b00);
      exp_r(1'b0, 32'h11, 2'b00, 1'b1);
      read_burst("rd_top", 8'hFC, 8'd0, 2'b01, 3'b010, 1'b0);
      exp_r(1'b0, 32'h22, 2'b00, 1'b1);
      read_burst("rd_zero", 8'h00, 8'd0, 2'b01, 3'b010, 1'b0);
      exp_r(1'b1, 32'h11, 2'b00, 1'b0); exp_r(1'b1, 32'h22, 2'b00, 1'b1);
      read_burst("rd_wrap_burst", 8'hFC, 8'd1, 2'b01, 3'b010, 1'b1);

      // ---- early WLAST, WRAP read, wrong-size read
      wd[0] = 32'h55; wd[1] = 32'h66;
      write_burst("wr_short", 8'h40, 8'd3, 2'b01, 3'b010, 2, 4'hF, 1'b0, 2'b10);
      exp_r(1'b1, 32'h0, 2'b10, 1'b0); exp_r(1'b1, 32'h0, 2'b10, 1'b1);
      read_burst("rd_wrap_type", 8'h10, 8'd1, 2'b10, 3'b010, 1'b1);
      exp_r(1'b0, 32'h0, 2'b10, 1'b1);
      read_burst("rd_bad_size", 8'h10, 8'd0, 2'b01, 3'b001, 1'b0);

      // ---- FIXED and wrong-size writes leave memory untouched
      wd[0] = 32'hDEAD_0001;
      write_burst("wr_fixed", 8'h10, 8'd0, 2'b00, 3'b010, 1, 4'hF, 1'b1, 2'b10);
      wd[0] = 32'hDEAD_0002;
      write_burst("wr_bad_size", 8'h14, 8'd0, 2'b01, 3'b001, 1, 4'hF, 1'b0, 2'b10);
      exp_r(1'b0, 32'hA0, 2'b00, 1'b0); exp_r(1'b0, 32'hA1, 2'b00, 1'b1);
      read_burst("rd_untouched", 8'h10, 8'd1, 2'b01, 3'b010, 1'b0);

      // ---- extra beat beyond AWLEN+1 is accepted but not written
      wd[0] = 32'h1234_5678;
      write_burst("wr_pre34", 8'h34, 8'd0, 2'b01, 3'b010, 1, 4'hF, 1'b0, 2'b00);
      wd[0] = 32'h77; wd[1] = 32'h88;
      write_burst("wr_long", 8'h30, 8'd0, 2'b01, 3'b010, 2, 4'hF, 1'b1, 2'b10);
      exp_r(1'b0, 32'h77, 2'b00, 1'b0); exp_r(1'b0, 32'h1234_5678, 2'b00, 1'b1);
      read_burst("rd_long", 8'h30, 8'd1, 2'b01, 3'b010, 1'b0);

      // ---- RREADY stalls
      stall_mode = 1'b1;
      exp_r(1'b1, 32'hA0, 2'b00, 1'b0); exp_r(1'b1, 32'hA1, 2'b00, 1'b0);
      exp_r(1'b1, 32'hA2, 2'b00, 1'b0); exp_r(1'b1, 32'hA3, 2'b00, 1'b1);
      read_burst("rd_stall", 8'h10, 8'd3, 2'b01, 3'b010, 1'b1);
      stall_mode = 1'b0;

      // ---- reset in the middle of a len 7 write
      @(posedge clk); #1;
      S_AXI_AWID = 1'b0; S_AXI_AWADDR = 8'h80; S_AXI_AWLEN = 8'd7;
      S_AXI_AWBURST = 2'b01; S_AXI_AWSIZE = 3'b010; S_AXI_AWVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 50);
      if (!S_AXI_AWREADY) chk("aw_timeout", 64'(S_AXI_AWREADY), 64'd1);
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = 32'hB0; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_WREADY && n < 50);
      if (!S_AXI_WREADY) chk("w_timeout", 64'(S_AXI_WREADY), 64'd1);
      @(posedge clk); #1;
      S_AXI_WDATA = 32'hB1;
      @(negedge clk);
      ARESET = 1'b1;
      #1;
      chk("rst_mid_ready_valid", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                      S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST}), 64'd0);
      S_AXI_WVALID = 1'b0;
      repeat (2) @(negedge clk);
      ARESET = 1'b0;
      #1;
      chk("mid_awready_before_edge", 64'(S_AXI_AWREADY), 64'd0);
      @(negedge clk);
      chk("mid_ready_after_release", 64'({S_AXI_AWREADY, S_AXI_ARREADY}), 64'b11);
      exp_r(1'b0, 32'hA0, 2'b00, 1'b0); exp_r(1'b0, 32'hA1, 2'b00, 1'b0);
      exp_r(1'b0, 32'hA2, 2'b00, 1'b0); exp_r(1'b0, 32'hA3, 2'b00, 1'b1);
      read_burst("rd_after_rst", 8'h10, 8'd3, 2'b01, 3'b010, 1'b0);
      exp_r(1'b1, 32'hFFFF_12FF, 2'b00, 1'b1);
      read_burst("rd_after_rst2", 8'h20, 8'd0, 2'b01, 3'b010, 1'b1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
